// File: rtl/gemm_tile_streamer_pkg.sv
// Shared types and constants for the GEMM tile streamers.
// A row beat carries one tile row plus its index and an end-of-tile marker.
package gemm_pkg;

    localparam int GEMM_LANES = 16;
    localparam int GEMM_DWID  = 8;
    localparam int GEMM_DIM_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } streamer_state_e;

    typedef struct packed {
        logic [GEMM_LANES*GEMM_DWID-1:0] data;
        logic [GEMM_DIM_W-1:0]           row;
        logic                            last;
    } row_beat_t;

endpackage

// File: rtl/gemm_tile_streamer_if.sv
// Scratchpad read port plus the outgoing row stream of the tile streamer.
// The master side is the streamer; the slave side is scratchpad plus consumer.
interface gemm_tile_streamer_if
    import gemm_pkg::*;
#(
    parameter int LANES = GEMM_LANES,
    parameter int D_WID = GEMM_DWID,
    parameter int DIM_W = GEMM_DIM_W
);
    logic                     mem_en;
    logic                     mem_rdwr;
    logic [4:0]               mem_control;
    logic [31:0]              mem_addr;
    logic [LANES*D_WID-1:0]   mem_rd_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*D_WID-1:0]   out_data;
    logic                     out_last;
    logic [DIM_W-1:0]         out_row;

    modport master (
        output mem_en, mem_rdwr, mem_control, mem_addr,
        input  mem_rd_data,
        output out_valid, out_data, out_last, out_row,
        input  out_ready
    );

    modport slave (
        input  mem_en, mem_rdwr, mem_control, mem_addr,
        output mem_rd_data,
        input  out_valid, out_data, out_last, out_row,
        output out_ready
    );

endinterface

// File: rtl/gemm_tile_streamer_fifo2.sv
// Two-entry FIFO of row beats; the head entry is a register driving dout directly.
// Reusable by any streamer that needs a guaranteed two-slot landing buffer.
module stream_fifo2
    import gemm_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  row_beat_t din,
    output row_beat_t dout,
    output logic      full,
    output logic      empty
);

    row_beat_t  head;
    row_beat_t  tail;
    logic [1:0] count;
    logic       pop_ok;
    logic       push_ok;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    head <= (count == 2'd1) ? din : tail;
                end
                default: ;
            endcase
        end
    end

    // The tail slot only holds data behind a valid head, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok && ((!pop_ok && count == 2'd1) || (pop_ok && count == 2'd2)))
            tail <= din;
    end

endmodule

// File: rtl/gemm_tile_streamer.sv
// Walks a strided tile row by row, issuing one unaligned scratchpad read per row
// and streaming the returned rows out through a credit-protected two-entry FIFO.
module gemm_tile_streamer
    import gemm_pkg::*;
#(
    parameter int LANES = GEMM_LANES,
    parameter int D_WID = GEMM_DWID,
    parameter int DIM_W = GEMM_DIM_W
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           base_addr,
    input  logic [DIM_W-1:0]      rows,
    input  logic [4:0]            cols,
    input  logic [15:0]           stride,
    output logic                  busy,
    output logic                  done,
    gemm_tile_streamer_if.master  bus
);

    localparam int BEAT_W = LANES * D_WID;

    streamer_state_e  state;
    streamer_state_e  state_nxt;
    logic [31:0]      addr_q;
    logic [4:0]       cols_q;
    logic [DIM_W-1:0] rows_q;
    logic [15:0]      stride_q;
    logic [DIM_W-1:0] issued_q;
    logic [DIM_W-1:0] issued_inc;
    logic             vld_p1;
    logic [DIM_W-1:0] row_p1;
    logic             last_p1;
    logic             issue;
    logic             credit_ok;
    logic             drained_nxt;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       occ;
    row_beat_t        beat_in;
    row_beat_t        beat_out;

    function automatic logic [BEAT_W-1:0] mask_lanes(input logic [BEAT_W-1:0] d,
                                                     input logic [4:0] n);
        logic [BEAT_W-1:0] m;
        m = d;
        for (int i = 0; i < LANES; i++)
            if (i >= int'(n)) m[i*D_WID +: D_WID] = '0;
        return m;
    endfunction

    assign issued_inc = issued_q + DIM_W'(1);
    assign occ        = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign pop        = !fifo_empty && bus.out_ready;
    // The scratchpad cannot stall, so every read must already own a FIFO slot.
    assign credit_ok  = ({1'b0, vld_p1} + occ - {1'b0, pop}) < 2'd2;
    assign drained_nxt = !vld_p1 && (fifo_empty || (!fifo_full && pop));

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (rows == '0 || cols == 5'd0) ? DRAIN : ISSUE;
            end
            ISSUE: begin
                issue = credit_ok;
                if (issue && issued_inc == rows_q) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drained_nxt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            cols_q   <= '0;
            issued_q <= '0;
            vld_p1   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= issue;
            done   <= (state == DRAIN) && drained_nxt;
            if (state == IDLE && start) begin
                addr_q   <= base_addr;
                cols_q   <= cols;
                issued_q <= '0;
            end else if (issue) begin
                addr_q   <= addr_q + 32'(stride_q);
                issued_q <= issued_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            rows_q   <= rows;
            stride_q <= stride;
        end
        if (issue) begin
            row_p1  <= issued_q;
            last_p1 <= (issued_inc == rows_q);
        end
    end

    // Stage p1 -> FIFO: read data returns one cycle after issue.
    assign beat_in.data = mask_lanes(bus.mem_rd_data, cols_q);
    assign beat_in.row  = row_p1;
    assign beat_in.last = last_p1;

    stream_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_p1),
        .pop   (pop),
        .din   (beat_in),
        .dout  (beat_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy            = (state != IDLE);
    assign bus.mem_en      = issue;
    assign bus.mem_rdwr    = 1'b0;
    assign bus.mem_control = cols_q;
    assign bus.mem_addr    = addr_q;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_data    = beat_out.data;
    assign bus.out_row     = beat_out.row;
    assign bus.out_last    = beat_out.last;

endmodule

// File: tb/tb_gemm_tile_streamer.sv
// Scoreboard bench for gemm_tile_streamer: expected beats are queued at issue
// time from an independent address model and matched against the output stream.
module tb_gemm_tile_streamer;

    typedef struct packed {
        logic [127:0] data;
        logic [7:0]   row;
        logic         last;
    } exp_beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [7:0]  rows;
    logic [4:0]  cols;
    logic [15:0] stride;
    logic        busy;
    logic        done;

    gemm_tile_streamer_if bus ();

    gemm_tile_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .rows      (rows),
        .cols      (cols),
        .stride    (stride),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    exp_beat_t   sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          t0 = 0;
    logic [31:0] exp_base = '0;
    logic [15:0] exp_stride = '0;
    logic [4:0]  exp_cols = '0;
    int          exp_rows = 0;
    int          tile_issued = 0;
    int          tile_beats = 0;
    int          n_issued = 0;
    int          n_accepted = 0;
    logic        ready_toggle = 1'b0;
    logic        stall_prev = 1'b0;
    logic [127:0] stall_data;
    logic [7:0]  stall_row;
    logic        stall_last;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] mem_row(input logic [31:0] a);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = (a[7:0] + 8'(i)) ^ 8'h5C;
        return r;
    endfunction

    function automatic logic [127:0] masked(input logic [127:0] d, input logic [4:0] n);
        logic [127:0] r;
        r = d;
        for (int i = 0; i < 16; i++) if (i >= int'(n)) r[i*8 +: 8] = 8'h00;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scratchpad model: data for the issued address appears one cycle later.
    always @(posedge clk) if (bus.mem_en) bus.mem_rd_data <= mem_row(bus.mem_addr);

    initial begin
        bus.out_ready = 1'b1;
        for (int k = 0; ; k++) begin
            @(posedge clk);
            #1;
            bus.out_ready = ready_toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_beat_t   e;
        logic [31:0] a;
        if (rst) begin
            sb.delete();
            stall_prev = 1'b0;
            n_issued   = 0;
            n_accepted = 0;
        end else begin
            if (start && !busy) begin
                tile_issued = 0;
                tile_beats  = 0;
            end
            if (stall_prev) begin
                check_eq("stall_valid", 128'(bus.out_valid), 128'(1));
                check_eq("stall_data", bus.out_data, stall_data);
                check_eq("stall_row", 128'(bus.out_row), 128'(stall_row));
                check_eq("stall_last", 128'(bus.out_last), 128'(stall_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                n_accepted++;
                tile_beats++;
                if (sb.size() == 0) begin
                    check_eq("unexpected_beat", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check_eq("out_data", bus.out_data, e.data);
                    check_eq("out_row", 128'(bus.out_row), 128'(e.row));
                    check_eq("out_last", 128'(bus.out_last), 128'(e.last));
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
            stall_row  = bus.out_row;
            stall_last = bus.out_last;
            if (bus.mem_en) begin
                a = exp_base + 32'(tile_issued) * 32'(exp_stride);
                check_eq("mem_addr", 128'(bus.mem_addr), 128'(a));
                check_eq("mem_control", 128'(bus.mem_control), 128'(exp_cols));
                check_eq("mem_rdwr", 128'(bus.mem_rdwr), 128'(0));
                e.data = masked(mem_row(a), exp_cols);
                e.row  = 8'(tile_issued);
                e.last = (tile_issued == exp_rows - 1);
                sb.push_back(e);
                tile_issued++;
                n_issued++;
                check_eq("outstanding_le2", 128'((n_issued - n_accepted) <= 2), 128'(1));
            end
        end
    end

    task automatic launch(input logic [31:0] b, input int nr, input logic [4:0] nc,
                          input logic [15:0] st);
        @(posedge clk);
        #1;
        exp_base   = b;
        exp_stride = st;
        exp_cols   = nc;
        exp_rows   = nr;
        base_addr  = b;
        rows       = 8'(nr);
        cols       = nc;
        stride     = st;
        start      = 1'b1;
        t0         = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("busy_t1", 128'(busy), 128'(1));
        check_eq("mem_en_t1", 128'(bus.mem_en), 128'(nr > 0 && nc != 5'd0));
    endtask

    task automatic wait_done(input int exp_lat, input int nr);
        int found;
        int lat;
        found = 0;
        lat   = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                lat   = cyc - t0;
                break;
            end
        end
        check_eq("done_seen", 128'(found), 128'(1));
        if (found == 1) begin
            if (exp_lat >= 0) check_eq("done_latency", 128'(lat), 128'(exp_lat));
            check_eq("busy_at_done", 128'(busy), 128'(0));
            check_eq("rows_issued", 128'(tile_issued), 128'(nr));
            check_eq("beats_out", 128'(tile_beats), 128'(nr));
            check_eq("sb_empty", 128'(sb.size()), 128'(0));
            @(negedge clk);
            check_eq("done_pulse", 128'(done), 128'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        rows      = '0;
        cols      = '0;
        stride    = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_done", 128'(done), 128'(0));
        check_eq("rst_mem_en", 128'(bus.mem_en), 128'(0));
        check_eq("rst_mem_rdwr", 128'(bus.mem_rdwr), 128'(0));
        check_eq("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check_eq("rst_out_last", 128'(bus.out_last), 128'(0));
        check_eq("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
        check_eq("rst_mem_control", 128'(bus.mem_control), 128'(0));
        check_eq("rst_out_data", bus.out_data, 128'(0));
        check_eq("rst_out_row", 128'(bus.out_row), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        launch(32'h23, 4, 5'd16, 16'd16);
        wait_done(7, 4);

        launch(32'h80, 2, 5'd5, 16'd16);
        wait_done(5, 2);

        ready_toggle = 1'b1;
        launch(32'h200, 6, 5'd16, 16'd24);
        wait_done(-1, 6);
        ready_toggle = 1'b0;

        launch(32'h300, 0, 5'd16, 16'd16);
        wait_done(2, 0);

        launch(32'h300, 3, 5'd0, 16'd16);
        wait_done(2, 0);

        launch(32'hFFFF_FFF0, 2, 5'd16, 16'h20);
        wait_done(5, 2);

        launch(32'h77, 3, 5'd9, 16'd0);
        wait_done(6, 3);

        // A second start while busy must not disturb the running tile.
        launch(32'h500, 3, 5'd16, 16'd16);
        @(posedge clk);
        #1;
        base_addr = 32'hDEAD;
        rows      = 8'd7;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6, 3);

        launch(32'h100, 5, 5'd16, 16'd16);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", 128'(busy), 128'(0));
        check_eq("midrst_valid", 128'(bus.out_valid), 128'(0));
        check_eq("midrst_done", 128'(done), 128'(0));
        launch(32'h400, 3, 5'd12, 16'h30);
        wait_done(6, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gemm_tile_streamer.md
# gemm_tile_streamer

Read-side stream engine for the GEMM datapath. Sits directly upstream of the banked scratchpad `memory`, where it drives the 16-lane interface port. It walks a strided matrix tile row by row, issuing one unaligned read of up to 16 bytes per row. Returned rows go into a small output buffer and leave on a valid/ready stream towards the systolic-array input skew logic.

## Interface
Parameters:
- `LANES`, 16 — bytes per row beat; equals scratchpad `NUM_RAMS`
- `D_WID`, 8 — bits per lane
- `DIM_W`, 8 — width of the row-count field

Ports (clock and reset first):
- `clk`  in  1  — single clock
- `rst`  in  1  — asynchronous, active-high reset
- `start`  in  1  — launch the tile walk; sampled only in IDLE
- `base_addr`  in  32  — byte address of row 0
- `rows`  in  DIM_W  — number of rows to fetch
- `cols`  in  5  — bytes per row, 1..16
- `stride`  in  16  — byte distance between consecutive row starts (unsigned)
- `busy`  out  1  — high from the cycle after an accepted start until done
- `done`  out  1  — one-cycle completion pulse
- `mem_en`  out  1  — scratchpad `interface_en`
- `mem_rdwr`  out  1  — scratchpad `interface_rdwr`; constant 0
- `mem_control`  out  5  — scratchpad `interface_control` (byte count)
- `mem_addr`  out  32  — scratchpad `interface_addr`
- `mem_rd_data`  in  LANES×D_WID  — scratchpad `interface_rd_data`; valid 1 cycle after `mem_en`
- `out_valid`  out  1  — row beat available
- `out_ready`  in  1  — consumer accepts the beat
- `out_data`  out  LANES×D_WID  — row bytes; lanes ≥ `cols` are zero
- `out_last`  out  1  — beat is the final row of the tile
- `out_row`  out  DIM_W  — row index of the beat, 0-based

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - `start`=1 latches `base_addr`, `rows`, `cols` and `stride`.
  - If `rows`==0 or `cols`==0: go to DRAIN with nothing issued, so `done` pulses the next cycle and no beats are produced.
  - Otherwise go to ISSUE.
- ISSUE: each cycle, if credit is available, drive `mem_en`=1, `mem_addr`=current address and `mem_control`=`cols`.
  - On each issue: current address += `stride`, 32-bit wrap-around; issued count += 1.
  - When issued count == `rows`, go to DRAIN.
- DRAIN: wait until every issued row has been accepted downstream, then pulse `done`, drop `busy` and return to IDLE.
- Credit rule: issue only when (reads in flight + FIFO occupancy) < 2.
  - The scratchpad cannot stall, so every issued read must have a guaranteed FIFO slot.
  - A same-cycle pop frees credit in that cycle. This gives full throughput.
- Return path:
  - An in-flight flag set on issue pushes `mem_rd_data` into the 2-entry FIFO the next cycle.
  - `out_row` and `out_last` travel alongside the data through the FIFO.
- `start` asserted while `busy`: ignored.
- `stride`=0 is legal and re-reads the same row `rows` times.
- `mem_rdwr` is never 1. This block does no writes.

## Timing
- Reset values: `busy`, `done`, `mem_en`, `mem_rdwr`, `out_valid` and `out_last` = 0; `mem_addr`, `mem_control`, `out_data` and `out_row` = 0; FSM = IDLE; FIFO empty; in-flight cleared.
- Sequence from `start` in cycle T:
  - T+1: `busy`=1 and first `mem_en`.
  - T+2: first `mem_rd_data` captured into the FIFO.
  - T+3: `out_valid`=1 at the earliest (registered FIFO output).
- With `out_ready` held high: 1 row per cycle sustained, and `done` arrives in cycle T+rows+3.
- Stream rule: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_row` and `out_last` hold stable.
- Stream rule: a beat transfers only on the cycle where `out_valid` && `out_ready`.
- `done` comes the cycle after the `out_last` handshake. `busy` falls in the same cycle `done` rises.
- `rst` mid-operation: immediate return to IDLE. In-flight read data is discarded and no `done` is produced.

## Structure
- Package `gemm_pkg` holds:
  - the `streamer_state_e` enum (IDLE/ISSUE/DRAIN)
  - the constants `GEMM_LANES`=16 and `GEMM_DWID`=8
  - the typedef `row_beat_t` (data, row, last)
- Sub-module `stream_fifo2`: a 2-entry synchronous FIFO of `row_beat_t` with registered outputs, push/pop/full/empty and the same clock/reset. It is reusable by the future write-back streamer.
- Credit counter, address generator and FSM live in the top module.

## Test plan
- `base_addr`=0x23, `rows`=4, `cols`=16, `stride`=16, `out_ready`=1 → `mem_addr` = 0x23, 0x33, 0x43, 0x53 on consecutive cycles; 4 beats back to back; `out_last` on row 3; `done` at T+7.
- `cols`=5, `rows`=2 → `mem_control`=5; `out_data` lanes 5..15 = 0 on both beats.
- `rows`=6 with `out_ready` toggling 1,0,0,1,… → no beat lost or duplicated; at most 2 reads outstanding; data stable while stalled.
- `rows`=0, or `cols`=0 → `mem_en` never asserted, no `out_valid`, `done` at T+2.
- `base_addr`=0xFFFF_FFF0, `stride`=0x20, `rows`=2 → second `mem_addr` = 0x0000_0010 (wrap).
- `rst` pulse during row 2 of 5, then a new `start` → no stale beat emerges; the new tile streams from its row 0.
